// File: rtl/rf_wb_arbiter_if.sv
// Writeback bus between the two writeback sources, the register file write port
// and the hazard lookup. The master side drives requests; the slave side is the arbiter.
interface rf_wb_arbiter_if #(
  parameter int DW = 32,
  parameter int AW = 5
);
  logic          a_valid;
  logic          a_ready;
  logic [AW-1:0] a_dest;
  logic [DW-1:0] a_data;
  logic          b_valid;
  logic          b_ready;
  logic [AW-1:0] b_dest;
  logic [DW-1:0] b_data;
  logic          rg_wrt_en;
  logic [AW-1:0] rg_wrt_dest;
  logic [DW-1:0] rg_wrt_data;
  logic [AW-1:0] chk_addr;
  logic          chk_hit;
  logic          b_pending;

  modport master (
    output a_valid, a_dest, a_data, b_valid, b_dest, b_data, chk_addr,
    input  a_ready, b_ready, rg_wrt_en, rg_wrt_dest, rg_wrt_data, chk_hit, b_pending
  );

  modport slave (
    input  a_valid, a_dest, a_data, b_valid, b_dest, b_data, chk_addr,
    output a_ready, b_ready, rg_wrt_en, rg_wrt_dest, rg_wrt_data, chk_hit, b_pending
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Register-file write port arbiter: A (priority, unbuffered) vs B (FIFO-buffered) with
// anti-starvation forcing and a pending-write hazard lookup. RF_ARB_STATS_EN adds grant counters.
module rf_wb_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5,
  parameter int B_DEPTH       = 4,
  parameter int STARVE_MAX    = 3
) (
  input  logic            clk,
  input  logic            rst,
  rf_wb_arbiter_if.slave  bus
`ifdef RF_ARB_STATS_EN
  ,
  output logic [15:0]     stat_a_wins,
  output logic [15:0]     stat_b_wins,
  output logic [15:0]     stat_forced
`endif
);
  localparam int PW = $clog2(B_DEPTH);
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [PW-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]              cnt_q, cnt_d;
  logic [SW-1:0]            starve_q, starve_d;
  logic                     out_en_q, out_en_d;
  logic [ADDRESS_WIDTH-1:0] out_dest_q, out_dest_d;
  logic [DATA_WIDTH-1:0]    out_data_q, out_data_d;
  logic [ADDRESS_WIDTH-1:0] mem_dest_q [B_DEPTH];
  logic [DATA_WIDTH-1:0]    mem_data_q [B_DEPTH];

  logic empty, full, force_b, grant_a, grant_b, push, hit;
  logic [PW-1:0] offs;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == (PW+1)'(B_DEPTH));
  assign force_b = (starve_q == SW'(STARVE_MAX)) && !empty;
  assign grant_a = bus.a_valid && !force_b;
  assign grant_b = force_b || (!bus.a_valid && !empty);
  // Full refuses a push even when a pop frees a slot this cycle.
  assign push    = bus.b_valid && !full;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    starve_d   = starve_q;
    out_en_d   = 1'b0;
    out_dest_d = out_dest_q;
    out_data_d = out_data_q;
    if (push)    wr_ptr_d = wr_ptr_q + PW'(1);
    if (grant_b) rd_ptr_d = rd_ptr_q + PW'(1);
    if (push && !grant_b)      cnt_d = cnt_q + (PW+1)'(1);
    else if (!push && grant_b) cnt_d = cnt_q - (PW+1)'(1);
    if (grant_b) begin
      starve_d   = '0;
      out_en_d   = (mem_dest_q[rd_ptr_q] != '0);
      out_dest_d = mem_dest_q[rd_ptr_q];
      out_data_d = mem_data_q[rd_ptr_q];
    end else if (grant_a) begin
      if (!empty && starve_q != SW'(STARVE_MAX)) starve_d = starve_q + SW'(1);
      out_en_d   = (bus.a_dest != '0);
      out_dest_d = bus.a_dest;
      out_data_d = bus.a_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      starve_q   <= '0;
      out_en_q   <= 1'b0;
      out_dest_q <= '0;
      out_data_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      starve_q   <= starve_d;
      out_en_q   <= out_en_d;
      out_dest_q <= out_dest_d;
      out_data_q <= out_data_d;
    end
  end

  // Storage needs no reset: validity comes only from the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_dest_q[wr_ptr_q] <= bus.b_dest;
      mem_data_q[wr_ptr_q] <= bus.b_data;
    end
  end

  // An entry is live when its distance from the read pointer is below the count.
  always_comb begin
    hit  = 1'b0;
    offs = '0;
    for (int i = 0; i < B_DEPTH; i++) begin
      offs = PW'(i) - rd_ptr_q;
      if (({1'b0, offs} < cnt_q) && (mem_dest_q[i] == bus.chk_addr)) hit = 1'b1;
    end
    if (out_en_q && (out_dest_q == bus.chk_addr)) hit = 1'b1;
  end

  assign bus.chk_hit     = hit && (bus.chk_addr != '0);
  assign bus.a_ready     = !force_b;
  assign bus.b_ready     = !full;
  assign bus.b_pending   = !empty;
  assign bus.rg_wrt_en   = out_en_q;
  assign bus.rg_wrt_dest = out_dest_q;
  assign bus.rg_wrt_data = out_data_q;

`ifdef RF_ARB_STATS_EN
  logic [15:0] sa_q, sa_d, sb_q, sb_d, sf_q, sf_d;

  always_comb begin
    sa_d = sa_q;
    sb_d = sb_q;
    sf_d = sf_q;
    if (grant_a && !grant_b && sa_q != 16'hFFFF) sa_d = sa_q + 16'd1;
    if (grant_b && sb_q != 16'hFFFF)             sb_d = sb_q + 16'd1;
    if (force_b && sf_q != 16'hFFFF)             sf_d = sf_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sa_q <= '0;
      sb_q <= '0;
      sf_q <= '0;
    end else begin
      sa_q <= sa_d;
      sb_q <= sb_d;
      sf_q <= sf_d;
    end
  end

  assign stat_a_wins = sa_q;
  assign stat_b_wins = sb_q;
  assign stat_forced = sf_q;
`endif
endmodule
